// File: rtl/fifo_pop_streamer.sv
// Pops a commanded number of elements from a registered-output FIFO and replays
// them as a valid/ready stream through a 2-entry skid buffer with credit-based pop issue.
module fifo_pop_streamer #(
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_abort,
    output logic             o_fifo_pop,
    input  logic             i_fifo_empty,
    input  logic [OUT_W-1:0] i_fifo_dout,
    output logic             o_fifo_clear,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg;
    logic [CNT_W-1:0] len_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       occ_reg;
    logic             inflight_reg;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic             done_reg;
    logic [OUT_W-1:0] buf_mem [0:1];

    logic deq, cap, active, abort_act, start_ok, start_zero, last_hs;
    logic [2:0] credit_used;

    assign active     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign abort_act  = i_abort & active;
    assign start_ok   = (state_reg == ST_IDLE) & i_start & ~i_abort & (i_len != '0);
    assign start_zero = (state_reg == ST_IDLE) & i_start & ~i_abort & (i_len == '0);

    assign o_valid = (occ_reg != 2'd0);
    assign o_data  = o_valid ? buf_mem[rd_ptr_reg] : '0;
    assign deq     = o_valid & i_ready;
    // FIFO data lands one cycle after the pop, so a pending pop always captures next edge
    assign cap     = inflight_reg;
    assign last_hs = deq & (count_reg == len_reg - CNT_ONE);

    // Credits: buffered + in-flight elements, less the one leaving this cycle, must stay below 2
    assign credit_used = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, deq};
    assign o_fifo_pop  = (state_reg == ST_RUN) & ~i_fifo_empty &
                         (remaining_reg != '0) & (credit_used < 3'd2);

    assign o_fifo_clear = i_abort;
    assign o_busy       = active;
    assign o_done       = done_reg;
    assign o_count      = count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_ok) state_next = ST_RUN;
            ST_RUN: begin
                if (i_abort)
                    state_next = ST_IDLE;
                else if (o_fifo_pop && remaining_reg == CNT_ONE)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_abort)
                    state_next = ST_IDLE;
                else if (last_hs)
                    state_next = ST_DONE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            len_reg       <= '0;
            count_reg     <= '0;
            occ_reg       <= 2'd0;
            inflight_reg  <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == ST_DONE) | start_zero;

            if (deq && count_reg < len_reg)
                count_reg <= count_reg + CNT_ONE;

            if (abort_act) begin
                // Anything still returning from the FIFO is dropped along with the buffer
                occ_reg       <= 2'd0;
                inflight_reg  <= 1'b0;
                remaining_reg <= '0;
                wr_ptr_reg    <= 1'b0;
                rd_ptr_reg    <= 1'b0;
            end else begin
                inflight_reg <= o_fifo_pop;
                occ_reg      <= occ_reg + {1'b0, cap} - {1'b0, deq};
                if (cap)
                    wr_ptr_reg <= ~wr_ptr_reg;
                if (deq)
                    rd_ptr_reg <= ~rd_ptr_reg;
                if (o_fifo_pop)
                    remaining_reg <= remaining_reg - CNT_ONE;
                if (start_ok) begin
                    remaining_reg <= i_len;
                    len_reg       <= i_len;
                    count_reg     <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (cap)
            buf_mem[wr_ptr_reg] <= i_fifo_dout;
    end

endmodule

// File: doc/fifo_pop_streamer.md
Name: fifo_pop_streamer

Overview:
- Downstream consumer of the wide-to-narrow FIFO.
- On command, pops exactly i_len narrow elements from the FIFO's pop/empty interface and re-presents them as a valid/ready stream toward the array feeders.
- Hides the FIFO's one-cycle registered-output latency with a 2-entry output buffer and credit-based pop issue.
- Reports progress, completion and abort.

Parameters:
OUT_W, 16, width of FIFO output element and stream data
CNT_W, 16, width of transfer length and delivered-element counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_len  in  CNT_W  elements to transfer; sampled with i_start
i_abort  in  1  synchronous abort of the current transfer
o_fifo_pop  out  1  pop request to FIFO
i_fifo_empty  in  1  FIFO empty flag (combinational, same cycle)
i_fifo_dout  in  OUT_W  FIFO data; valid the cycle after the pop
o_fifo_clear  out  1  one-cycle clear pulse to FIFO on abort
o_valid  out  1  stream valid
o_data  out  OUT_W  stream data
i_ready  in  1  stream ready
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle completion pulse
o_count  out  CNT_W  elements handshaken in the current or last transfer

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high.
- On i_rst, all state is cleared: state=IDLE, buffer occ=0, inflight=0, remaining=0. All outputs are 0: o_fifo_pop, o_fifo_clear, o_valid, o_data, o_busy, o_done, o_count.
- Reset mid-transfer drops all data and does not pulse o_fifo_clear.
- FSM states:
  - IDLE: on i_start with i_len>0, latch remaining=i_len, clear o_count, go to RUN. On i_start with i_len==0, o_done=1 next cycle and stay in IDLE, with no pops and o_busy never high.
  - RUN: issue pops. When the pop that makes remaining reach 0 is issued, go to DRAIN.
  - DRAIN: wait for the last element to be handshaken.
  - DONE: one cycle, o_done=1, then IDLE.
- o_busy=1 in RUN and DRAIN.
- Pop rule (combinational): o_fifo_pop = RUN & !i_fifo_empty & (remaining>0) & ((occ + inflight - deq) < 2), where deq = o_valid & i_ready.
  - Invariant: occ + inflight <= 2 at all times.
  - Full throughput of one element per cycle is sustained when the FIFO is non-empty and i_ready=1.
- Latency:
  - Pop in cycle t sets inflight; i_fifo_dout is captured into the buffer at the end of cycle t+1.
  - o_valid is high from cycle t+2 at the earliest.
  - inflight clears on capture.
- Buffer is a 2-entry in-order FIFO; o_data/o_valid show its head.
  - Simultaneous capture and deq is allowed.
  - Overflow is impossible by the credit rule.
- Stream handshake:
  - Transfer occurs when o_valid & i_ready.
  - While o_valid & !i_ready, o_data is stable.
  - o_valid never drops without a handshake, except on abort or reset.
- o_count increments on each handshake and saturates at i_len.
- DONE is entered the cycle after the i_len-th handshake, so o_done is high in that following cycle.
- i_start while busy is ignored. i_start and i_abort together in IDLE: abort wins, start is ignored.
- i_abort in RUN/DRAIN:
  - o_fifo_clear=1 in the same cycle.
  - Next cycle: state=IDLE, occ=0, inflight=0, o_valid=0, o_busy=0.
  - The returning in-flight data is discarded.
  - No o_done pulse; o_count holds its value.
- i_abort in IDLE/DONE: o_fifo_clear pulses and the state is otherwise unchanged.
- remaining and the counters use CNT_W-bit unsigned arithmetic with no wrap; remaining is never decremented below 0.

Test Plan:
- Basic transfer: start (cycle 0), len=4, FIFO holding D0..D3, i_ready=1 -> o_fifo_pop in cycles 1-4; o_valid in cycles 3-6 with D0..D3 in order; o_done=1 in cycle 7; o_count=4; o_busy high in cycles 1-6.
- Backpressure: len=8, i_ready=0 from cycle 3 for 5 cycles -> exactly 2 pops issued before the stall, then o_fifo_pop=0; o_data=D0 stable throughout; on release D0..D7 delivered with no loss or duplication.
- Empty gaps: len=6, i_fifo_empty toggling every 2 cycles -> o_fifo_pop never high while empty; stream order D0..D5; o_done after the 6th handshake.
- Abort: len=10, i_abort after 3 handshakes -> o_fifo_clear=1 that cycle; next cycle o_valid=0, o_busy=0; o_count=3; no o_done; a following start with len=2 completes normally.
- Zero length: start with len=0 -> o_done=1 the next cycle; no pops; o_busy stays 0; start while busy is ignored (len is not re-latched).
- Reset mid-transfer: i_rst during DRAIN -> all outputs 0 next cycle; o_fifo_clear not pulsed; FSM in IDLE.
